// File: rtl/button_debounce_pkg.sv
// Shared debounce definitions: FSM state encodings and the counter-width helper.
package button_debounce_pkg;

    typedef enum logic {
        STABLE_LOW  = 1'b0,
        STABLE_HIGH = 1'b1
    } deb_state_e;

    // A 1- or 2-cycle qualifier still needs a 1-bit counter to be representable.
    function automatic int deb_cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchronizer, qualification counter, 2-state FSM.
// Optional one-cycle rising-edge strobe when BUTTON_PULSE_EN is defined.
module debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_button,
    output logic o_signal
`ifdef BUTTON_PULSE_EN
    ,
    output logic o_pulse
`endif
);

    localparam int              CNT_W    = deb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_button;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any agreeing sample restarts qualification; the last disagreeing one flips state.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (sync2_q != logic'(state_q)) begin
            if (cnt_q == CNT_LAST) begin
                state_d = (state_q == STABLE_LOW) ? STABLE_HIGH : STABLE_LOW;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        o_signal = (state_q == STABLE_HIGH);
    end

`ifdef BUTTON_PULSE_EN
    logic pulse_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= (state_q == STABLE_LOW) && (state_d == STABLE_HIGH);
        end
    end

    assign o_pulse = pulse_q;
`endif

endmodule

// File: rtl/button_debounce.sv
// Multi-channel pushbutton debouncer; each bit is an independent debounce_channel.
// Define BUTTON_PULSE_EN to add the o_pulse rising-edge strobe port.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int N_BUTTON        = 1,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [N_BUTTON-1:0] i_button,
    output logic [N_BUTTON-1:0] o_signal
`ifdef BUTTON_PULSE_EN
    ,
    output logic [N_BUTTON-1:0] o_pulse
`endif
);

    generate
        for (genvar gi = 0; gi < N_BUTTON; gi++) begin : g_chan
            debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_chan (
                .i_clock (i_clock),
                .i_reset (i_reset),
                .i_button(i_button[gi]),
                .o_signal(o_signal[gi])
`ifdef BUTTON_PULSE_EN
                ,
                .o_pulse (o_pulse[gi])
`endif
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (N_BUTTON=2, DEBOUNCE_CYCLES=4): directed
// scenarios plus randomized bouncing against a sliding-window reference model.
module tb_button_debounce;

    localparam int NB   = 2;
    localparam int DC   = 4;
    localparam int MAXE = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn;
    logic [NB-1:0] sig;
`ifdef BUTTON_PULSE_EN
    logic [NB-1:0] pul;
    logic [NB-1:0] p_m;
`endif

    always #5 clk = ~clk;

    button_debounce #(
        .N_BUTTON(NB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_button(btn),
        .o_signal(sig)
`ifdef BUTTON_PULSE_EN
        ,
        .o_pulse (pul)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a history of what each edge saw, and a window rule on top of it.
    logic [NB-1:0] eff_a [MAXE];
    logic          rst_a [MAXE];
    logic [NB-1:0] o_m;
    int            last_ev [NB];
    int            ecount = 0;

    // Synchronized level the debouncer compares against at edge j.
    function automatic logic seen(input int j, input int ch);
        if (j < 2) return 1'b0;
        if (rst_a[j-1]) return 1'b0;
        return eff_a[j-2][ch];
    endfunction

    // Output flips when the last DC edges since the last reset/flip all disagreed with it.
    task automatic model_edge();
        int  k;
        bit  all_diff;
        k = ecount;
        eff_a[k] = rst ? '0 : btn;
        rst_a[k] = rst;
        for (int ch = 0; ch < NB; ch++) begin
`ifdef BUTTON_PULSE_EN
            p_m[ch] = 1'b0;
`endif
            if (rst) begin
                o_m[ch]     = 1'b0;
                last_ev[ch] = k;
            end else if (k - last_ev[ch] >= DC) begin
                all_diff = 1'b1;
                for (int j = k - DC + 1; j <= k; j++)
                    if (seen(j, ch) == o_m[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    o_m[ch]     = ~o_m[ch];
                    last_ev[ch] = k;
`ifdef BUTTON_PULSE_EN
                    p_m[ch] = o_m[ch];
`endif
                end
            end
        end
        ecount++;
    endtask

    task automatic step(input logic r, input logic [NB-1:0] b);
        rst = r;
        btn = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk($sformatf("model_sig_e%0d", ecount - 1), sig, o_m);
`ifdef BUTTON_PULSE_EN
        chk($sformatf("model_pulse_e%0d", ecount - 1), pul, p_m);
`endif
    endtask

    task automatic pulse_exp(input string tag, input logic [NB-1:0] exp);
`ifdef BUTTON_PULSE_EN
        chk(tag, pul, exp);
`else
        if (tag.len() == 0 && exp != 0) $display("note: empty tag");
`endif
    endtask

    logic [0:13]   bpat = 14'b10110111111111;
    int            hold [NB];
    logic [NB-1:0] rb;

    initial begin
        o_m = '0;
        rst = 1'b1;
        btn = '0;

        // Reset state
        step(1'b1, 2'b00);
        step(1'b1, 2'b11);
        chk("reset_sig", sig, 2'b00);
        pulse_exp("reset_pulse", 2'b00);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00);

        // Clean press on channel 0
        for (int e = 0; e <= 6; e++) begin
            step(1'b0, 2'b01);
            chk($sformatf("press_sig_e%0d", e), sig, (e >= 5) ? 2'b01 : 2'b00);
            pulse_exp($sformatf("press_pulse_e%0d", e), (e == 5) ? 2'b01 : 2'b00);
        end

        // Release
        for (int e = 0; e <= 6; e++) begin
            step(1'b0, 2'b00);
            chk($sformatf("release_sig_e%0d", e), sig, (e >= 5) ? 2'b00 : 2'b01);
            pulse_exp($sformatf("release_pulse_e%0d", e), 2'b00);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 2'b00);

        // Bounce: final 0->1 at e=5, rise expected 5 edges later
        for (int e = 0; e < 14; e++) begin
            step(1'b0, {1'b0, bpat[e]});
            chk($sformatf("bounce_sig_e%0d", e), sig, (e >= 10) ? 2'b01 : 2'b00);
            pulse_exp($sformatf("bounce_pulse_e%0d", e), (e == 10) ? 2'b01 : 2'b00);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 2'b00);
        chk("bounce_low_again", sig, 2'b00);

        // Simultaneous press on both channels
        for (int e = 0; e <= 6; e++) begin
            step(1'b0, 2'b11);
            chk($sformatf("simul_sig_e%0d", e), sig, (e >= 5) ? 2'b11 : 2'b00);
            pulse_exp($sformatf("simul_pulse_e%0d", e), (e == 5) ? 2'b11 : 2'b00);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 2'b00);
        chk("simul_low_again", sig, 2'b00);

        // Reset in the middle of qualification
        for (int e = 0; e < 3; e++) step(1'b0, 2'b01);
        for (int e = 0; e < 2; e++) begin
            step(1'b1, 2'b01);
            chk($sformatf("rstmid_sig_r%0d", e), sig, 2'b00);
            pulse_exp($sformatf("rstmid_pulse_r%0d", e), 2'b00);
        end
        for (int e = 0; e <= 6; e++) begin
            step(1'b0, 2'b01);
            chk($sformatf("rstmid_sig_e%0d", e), sig, (e >= 5) ? 2'b01 : 2'b00);
            pulse_exp($sformatf("rstmid_pulse_e%0d", e), (e == 5) ? 2'b01 : 2'b00);
        end

        // Randomized bouncing: each channel holds a level for 1..7 edges
        rb = btn;
        for (int ch = 0; ch < NB; ch++) hold[ch] = 0;
        for (int n = 0; n < 2000; n++) begin
            for (int ch = 0; ch < NB; ch++) begin
                if (hold[ch] == 0) begin
                    rb[ch]   = ~rb[ch];
                    hold[ch] = int'($urandom_range(1, 7));
                end
                hold[ch]--;
            end
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter N_BUTTON, default 1, giving the number of independent button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000, giving the number of consecutive stable synchronized samples needed to accept a level change; legal range 1 to 2^20.
REQ-003 The block SHALL have port i_clock, input, 1 bit: single clock for all logic.
REQ-004 The block SHALL have port i_reset, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port i_button, input, N_BUTTON bits: raw asynchronous bouncy pushbutton levels.
REQ-006 The block SHALL have port o_signal, output, N_BUTTON bits: debounced registered level, suitable to drive the button toggle logic's i_signal.
REQ-007 The block SHALL have port o_pulse, output, N_BUTTON bits: one-cycle rising-edge strobe; present only when BUTTON_PULSE_EN is defined (REQ-024).

Function
REQ-008 Each channel SHALL pass i_button[i] through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-009 Each channel SHALL run a 2-state FSM, STABLE_LOW and STABLE_HIGH, with o_signal[i] = 1 exactly in STABLE_HIGH.
REQ-010 Each channel SHALL have a counter of width clog2(DEBOUNCE_CYCLES) (min 1) that increments on every edge where sync2 differs from the current state.
REQ-011 The counter SHALL clear to 0 on any edge where sync2 equals the current state, so a single agreeing sample restarts the qualification.
REQ-012 On an edge where sync2 differs from the state and the counter equals DEBOUNCE_CYCLES-1, the FSM SHALL change state (STABLE_LOW<->STABLE_HIGH) and the counter SHALL clear to 0.
REQ-013 Latency: a clean i_button change first sampled at edge 0 SHALL appear on o_signal after edge DEBOUNCE_CYCLES+1, in both directions.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL NOT change o_signal.
REQ-015 The counter SHALL never wrap; it saturates at the transition point per REQ-012.
REQ-016 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each be qualified with no interaction.
REQ-017 With DEBOUNCE_CYCLES = 1, o_signal SHALL follow sync2 with one extra register stage (latency 2).

Reset
REQ-018 While i_reset is high at a clock edge, sync1, sync2, counters, FSM state (STABLE_LOW), o_signal and o_pulse SHALL all be 0.
REQ-019 Reset asserted mid-qualification SHALL discard the partial count.
REQ-020 After reset deasserts with i_button held high, o_signal SHALL rise after edge DEBOUNCE_CYCLES+1, counting from the first edge with i_reset low as edge 0.
REQ-021 Reset SHALL have no asynchronous path.

Configuration
REQ-022 Macro BUTTON_PULSE_EN SHALL control the o_pulse feature.
REQ-023 Without BUTTON_PULSE_EN, port o_pulse and its registers SHALL be absent; o_signal behaviour is unchanged.
REQ-024 With BUTTON_PULSE_EN, o_pulse[i] SHALL be registered and high for exactly one cycle, on the same edge o_signal[i] goes 0->1.
REQ-025 With BUTTON_PULSE_EN, o_pulse SHALL never assert on a 1->0 transition or during reset.

Structure
REQ-026 FSM state encodings (STABLE_LOW=1'b0, STABLE_HIGH=1'b1) and the counter-width function SHALL live in the shared project header/package, not in this module.
REQ-027 Per-channel logic SHALL be a sub-module debounce_channel (synchronizer, counter, FSM, optional pulse), instantiated N_BUTTON times by a generate loop.

Verification (DEBOUNCE_CYCLES=4, N_BUTTON=2 unless noted)
REQ-028 Clean press: i_button[0] 0->1 sampled at edge 0 and held -> o_signal[0]=1 after edge 5; o_pulse[0]=1 for that cycle only; channel 1 stays 0.
REQ-029 Bounce: i_button[0] pattern 1,0,1,1,0,1,1,1,1,... -> o_signal[0] rises only 5 edges after the final 0->1, with no intermediate toggles.
REQ-030 Release: after a stable high, drive i_button[0]=0 at edge 0 -> o_signal[0]=0 after edge 5; o_pulse stays 0.
REQ-031 Simultaneous: both bits rise at the same edge -> both o_signal bits rise at the same edge 5 and both pulses fire together.
REQ-032 Reset mid-count: i_button=1, assert i_reset at edge 3 for 2 cycles -> outputs 0; o_signal rises 5 edges after the first non-reset edge.
REQ-033 Build without BUTTON_PULSE_EN -> compiles with no o_pulse port; scenarios REQ-028 to REQ-032 give identical o_signal results.
